// File: rtl/spi_xfer_sequencer_if.sv
// Signal bundle between the SPI_CNT register logic, the TX/RX block buffers,
// the SPI pins and the transfer sequencer.
interface spi_xfer_sequencer_if #(
   parameter int unsigned BUF_ADDR_W = 9,
   parameter int unsigned DIV_W      = 3
);
   logic                  Start;
   logic                  Abort;
   logic [1:0]            Mode;
   logic [BUF_ADDR_W-1:0] Length;
   logic [DIV_W-1:0]      ClkDiv;
   logic                  Busy;
   logic                  Done;
   logic [BUF_ADDR_W-1:0] TxBufAddr;
   logic                  TxBufRe;
   logic [7:0]            TxBufData;
   logic [BUF_ADDR_W-1:0] RxBufAddr;
   logic                  RxBufWe;
   logic [7:0]            RxBufData;
   logic                  SPIClk;
   logic                  SPIDo;
   logic                  SPIDi;

   modport master (
      output Start, Abort, Mode, Length, ClkDiv, TxBufData, SPIDi,
      input  Busy, Done, TxBufAddr, TxBufRe, RxBufAddr, RxBufWe, RxBufData, SPIClk, SPIDo
   );

   modport slave (
      input  Start, Abort, Mode, Length, ClkDiv, TxBufData, SPIDi,
      output Busy, Done, TxBufAddr, TxBufRe, RxBufAddr, RxBufWe, RxBufData, SPIClk, SPIDo
   );
endinterface

// File: rtl/spi_xfer_sequencer.sv
// Multi-byte SPI mode-0 transfer sequencer: fetches TX bytes, shifts them MSB
// first while capturing SPIDi, and writes the received bytes to the RX buffer.
module spi_xfer_sequencer #(
   parameter int unsigned BUF_ADDR_W = 9,
   parameter int unsigned DIV_W      = 3
) (
   input logic                   FastClk,
   input logic                   Reset,
   spi_xfer_sequencer_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_STORE
   } state_t;

   state_t                state;
   logic [1:0]            mode_l;
   logic [BUF_ADDR_W-1:0] len_l;
   logic [DIV_W-1:0]      div_l;
   logic [BUF_ADDR_W-1:0] idx;
   logic [DIV_W-1:0]      dcnt;
   logic [3:0]            hcnt;
   logic [7:0]            sr;
   logic                  rx_bit;
   logic                  first_cyc;
   logic                  spido_q;

   logic                  busy_q;
   logic                  done_q;
   logic                  tx_re_q;
   logic [BUF_ADDR_W-1:0] tx_addr_q;
   logic                  rx_we_q;
   logic [BUF_ADDR_W-1:0] rx_addr_q;
   logic [7:0]            rx_data_q;
   logic                  spiclk_q;

   logic                  rx_only;
   logic                  tx_only;
   logic [7:0]            load_byte;
   logic                  half_end;
   logic                  in_bit;
   logic [7:0]            sr_shift;

   always_comb begin
      rx_only   = (mode_l == 2'd1);
      tx_only   = (mode_l == 2'd0);
      load_byte = rx_only ? 8'hFF : bus.TxBufData;
      half_end  = (dcnt == div_l);
      // With a one-cycle half the sampling cycle is also the shift cycle.
      in_bit    = (dcnt == '0) ? bus.SPIDi : rx_bit;
      sr_shift  = {sr[6:0], in_bit};
   end

   always_ff @(posedge FastClk) begin
      if (Reset) begin
         state     <= S_IDLE;
         mode_l    <= '0;
         len_l     <= '0;
         div_l     <= '0;
         idx       <= '0;
         dcnt      <= '0;
         hcnt      <= '0;
         sr        <= '0;
         rx_bit    <= 1'b0;
         first_cyc <= 1'b0;
         spido_q   <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         tx_re_q   <= 1'b0;
         tx_addr_q <= '0;
         rx_we_q   <= 1'b0;
         rx_addr_q <= '0;
         rx_data_q <= '0;
         spiclk_q  <= 1'b0;
      end else if (bus.Abort) begin
         state     <= S_IDLE;
         first_cyc <= 1'b0;
         spido_q   <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         tx_re_q   <= 1'b0;
         rx_we_q   <= 1'b0;
         spiclk_q  <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         tx_re_q   <= 1'b0;
         rx_we_q   <= 1'b0;
         first_cyc <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.Start) begin
                  mode_l    <= bus.Mode;
                  len_l     <= bus.Length;
                  div_l     <= bus.ClkDiv;
                  idx       <= '0;
                  busy_q    <= 1'b1;
                  tx_re_q   <= (bus.Mode != 2'd1);
                  tx_addr_q <= '0;
                  state     <= S_LOAD;
               end
            end
            S_LOAD: begin
               hcnt      <= '0;
               dcnt      <= '0;
               spiclk_q  <= 1'b0;
               first_cyc <= 1'b1;
               state     <= S_SHIFT;
            end
            S_SHIFT: begin
               // Buffer read data arrives on the first SHIFT cycle; SPIDo
               // bypasses it combinationally until the register holds it.
               if (first_cyc) begin
                  sr      <= load_byte;
                  spido_q <= load_byte[7];
               end
               if (hcnt[0] && (dcnt == '0))
                  rx_bit <= bus.SPIDi;
               if (half_end) begin
                  dcnt <= '0;
                  if (hcnt[0]) begin
                     sr <= sr_shift;
                     if (hcnt != 4'd15)
                        spido_q <= sr_shift[7];
                  end
                  if (hcnt == 4'd15) begin
                     spiclk_q  <= 1'b0;
                     rx_we_q   <= !tx_only;
                     rx_addr_q <= idx;
                     rx_data_q <= sr_shift;
                     state     <= S_STORE;
                  end else begin
                     hcnt     <= hcnt + 4'd1;
                     spiclk_q <= ~hcnt[0];
                  end
               end else begin
                  dcnt <= dcnt + 1'b1;
               end
            end
            S_STORE: begin
               if (idx == len_l) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  spido_q <= 1'b1;
                  state   <= S_IDLE;
               end else begin
                  idx       <= idx + 1'b1;
                  tx_re_q   <= !rx_only;
                  tx_addr_q <= idx + 1'b1;
                  state     <= S_LOAD;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.Busy      = busy_q;
   assign bus.Done      = done_q;
   assign bus.TxBufRe   = tx_re_q;
   assign bus.TxBufAddr = tx_addr_q;
   assign bus.RxBufWe   = rx_we_q;
   assign bus.RxBufAddr = rx_addr_q;
   assign bus.RxBufData = rx_data_q;
   assign bus.SPIClk    = spiclk_q;
   assign bus.SPIDo     = first_cyc ? load_byte[7] : spido_q;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer with TX/RX buffer models and SPIDi sources.
module tb_spi_xfer_sequencer;

   logic FastClk = 1'b0;
   logic Reset;
   always #5 FastClk = ~FastClk;

   spi_xfer_sequencer_if #(.BUF_ADDR_W(9), .DIV_W(3)) bus ();

   spi_xfer_sequencer #(.BUF_ADDR_W(9), .DIV_W(3)) dut (
      .FastClk (FastClk),
      .Reset   (Reset),
      .bus     (bus)
   );

   int total = 0;
   int bad   = 0;

   logic [7:0] tx_mem [512];
   logic [7:0] rx_mem [512];
   int         wr_cnt [512];
   logic       rx_clear;
   int         si_sel;
   logic       clk_d;

   int cyc = 0;
   int done_cnt = 0, done_cyc = 0, we_cnt = 0, we_gap = 0, last_we_cyc = 0, last_we_addr = 0;
   int re_cnt = 0, busy_cnt = 0, do_low = 0, rise_cnt = 0, rise_gap = 0, last_rise = 0;
   int hi_run = 0, hi_bad = 0, do_bad = 0, exp_hi = 1;
   logic prev_clk = 1'b0, prev_do = 1'b1;
   int start_cyc = 0;

   always @(posedge FastClk) cyc <= cyc + 1;

   always @(posedge FastClk) begin
      clk_d <= bus.SPIClk;
      if (bus.TxBufRe) bus.TxBufData <= tx_mem[bus.TxBufAddr];
   end

   always @(posedge FastClk) begin
      if (rx_clear) begin
         for (int i = 0; i < 512; i++) begin
            rx_mem[i] <= 8'h5A;
            wr_cnt[i] <= 0;
         end
      end else if (bus.RxBufWe) begin
         rx_mem[bus.RxBufAddr] <= bus.RxBufData;
         wr_cnt[bus.RxBufAddr] <= wr_cnt[bus.RxBufAddr] + 1;
      end
   end

   // SPIDi sources: 0 = constant low, 1 = loopback, 2 = loopback only on the first high cycle
   always_comb begin
      case (si_sel)
         0:       bus.SPIDi = 1'b0;
         1:       bus.SPIDi = bus.SPIDo;
         default: bus.SPIDi = (bus.SPIClk && !clk_d) ? bus.SPIDo : ~bus.SPIDo;
      endcase
   end

   always @(negedge FastClk) begin
      if (bus.Done) begin done_cnt++; done_cyc = cyc; end
      if (bus.RxBufWe) begin
         we_cnt++; we_gap = cyc - last_we_cyc; last_we_cyc = cyc; last_we_addr = int'(bus.RxBufAddr);
      end
      if (bus.TxBufRe) re_cnt++;
      if (bus.Busy) busy_cnt++;
      if (bus.Busy && !bus.SPIDo) do_low++;
      if (bus.SPIClk && !prev_clk) begin
         rise_cnt++; rise_gap = cyc - last_rise; last_rise = cyc; hi_run = 1;
      end else if (bus.SPIClk) begin
         hi_run++;
      end
      if (!bus.SPIClk && prev_clk && hi_run != exp_hi) hi_bad++;
      if (bus.SPIDo != prev_do && bus.SPIClk) do_bad++;
      prev_clk = bus.SPIClk;
      prev_do  = bus.SPIDo;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge FastClk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_rx();
      rx_clear = 1'b1;
      tick();
      rx_clear = 1'b0;
   endtask

   task automatic start_xfer(input logic [1:0] m, input logic [8:0] l, input logic [2:0] d);
      bus.Mode   = m;
      bus.Length = l;
      bus.ClkDiv = d;
      bus.Start  = 1'b1;
      start_cyc  = cyc;
      tick();
      bus.Start  = 1'b0;
      bus.Mode   = ~m;
      bus.Length = ~l;
      bus.ClkDiv = ~d;
   endtask

   task automatic wait_done(input int base, input int maxc, input string tag);
      int n = 0;
      while (done_cnt == base && n < maxc) begin
         tick();
         n++;
      end
      chk(tag, 32'(done_cnt != base), 32'd1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_busy"}, 32'(bus.Busy), 32'd0);
      chk({tag, "_done"}, 32'(bus.Done), 32'd0);
      chk({tag, "_txre"}, 32'(bus.TxBufRe), 32'd0);
      chk({tag, "_rxwe"}, 32'(bus.RxBufWe), 32'd0);
      chk({tag, "_sclk"}, 32'(bus.SPIClk), 32'd0);
      chk({tag, "_sdo"}, 32'(bus.SPIDo), 32'd1);
      chk({tag, "_txaddr"}, 32'(bus.TxBufAddr), 32'd0);
      chk({tag, "_rxaddr"}, 32'(bus.RxBufAddr), 32'd0);
   endtask

   initial begin
      int b_done, b_we, b_re, b_busy, b_rise, b_hi, b_low, errs, n;
      Reset = 1'b1;
      bus.Start = 1'b0; bus.Abort = 1'b0; bus.Mode = 2'd2; bus.Length = '0; bus.ClkDiv = '0;
      si_sel = 1; rx_clear = 1'b0;
      for (int i = 0; i < 512; i++) tx_mem[i] = 8'(i);
      repeat (3) tick();
      chk_reset_vals("reset");
      Reset = 1'b0;
      tick();

      // 1: single byte exchange, fastest clock
      tx_mem[0] = 8'hA5;
      clear_rx();
      b_done = done_cnt; b_busy = busy_cnt; b_we = we_cnt;
      exp_hi = 1;
      start_xfer(2'd2, 9'd0, 3'd0);
      wait_done(b_done, 100, "t1_timeout");
      tick();
      chk("t1_rx0", 32'(rx_mem[0]), 32'hA5);
      chk("t1_done_lat", 32'(done_cyc - start_cyc), 32'd19);
      chk("t1_busy_len", 32'(busy_cnt - b_busy), 32'd18);
      chk("t1_we_cnt", 32'(we_cnt - b_we), 32'd1);

      // 2: full 512-byte buffer
      tx_mem[0] = 8'h00;
      clear_rx();
      b_done = done_cnt; b_we = we_cnt;
      start_xfer(2'd2, 9'h1FF, 3'd0);
      wait_done(b_done, 10000, "t2_timeout");
      tick();
      errs = 0;
      for (int i = 0; i < 512; i++)
         if (rx_mem[i] !== 8'(i) || wr_cnt[i] != 1) errs++;
      chk("t2_data_errs", 32'(errs), 32'd0);
      chk("t2_we_cnt", 32'(we_cnt - b_we), 32'd512);
      chk("t2_done_cnt", 32'(done_cnt - b_done), 32'd1);
      chk("t2_last_addr", 32'(last_we_addr), 32'd511);

      // 3: RX-only with SPIDi low, then TX-only
      clear_rx();
      si_sel = 0; exp_hi = 2;
      b_done = done_cnt; b_we = we_cnt; b_re = re_cnt; b_low = do_low;
      start_xfer(2'd1, 9'd3, 3'd1);
      wait_done(b_done, 300, "t3a_timeout");
      tick();
      chk("t3a_re_cnt", 32'(re_cnt - b_re), 32'd0);
      chk("t3a_sdo_low", 32'(do_low - b_low), 32'd0);
      chk("t3a_we_cnt", 32'(we_cnt - b_we), 32'd4);
      errs = 0;
      for (int i = 0; i < 4; i++) if (rx_mem[i] !== 8'h00) errs++;
      chk("t3a_rx_zero", 32'(errs), 32'd0);
      b_done = done_cnt; b_we = we_cnt; b_re = re_cnt;
      start_xfer(2'd0, 9'd3, 3'd1);
      wait_done(b_done, 300, "t3b_timeout");
      tick();
      chk("t3b_re_cnt", 32'(re_cnt - b_re), 32'd4);
      chk("t3b_we_cnt", 32'(we_cnt - b_we), 32'd0);

      // 4: divided clock, SPIDi valid only on the first high cycle
      tx_mem[0] = 8'h3C; tx_mem[1] = 8'hC3;
      clear_rx();
      si_sel = 2; exp_hi = 4;
      b_done = done_cnt; b_rise = rise_cnt; b_hi = hi_bad;
      start_xfer(2'd2, 9'd1, 3'd3);
      wait_done(b_done, 300, "t4_timeout");
      tick();
      chk("t4_rx0", 32'(rx_mem[0]), 32'h3C);
      chk("t4_rx1", 32'(rx_mem[1]), 32'hC3);
      chk("t4_done_lat", 32'(done_cyc - start_cyc), 32'd133);
      chk("t4_byte_period", 32'(we_gap), 32'd66);
      chk("t4_rises", 32'(rise_cnt - b_rise), 32'd16);
      chk("t4_sclk_period", 32'(rise_gap), 32'd8);
      chk("t4_high_len", 32'(hi_bad - b_hi), 32'd0);

      // 5: abort during byte 2, then a clean restart
      for (int i = 0; i < 8; i++) tx_mem[i] = 8'h10 + 8'(i);
      clear_rx();
      si_sel = 1; exp_hi = 1;
      b_done = done_cnt; b_we = we_cnt;
      start_xfer(2'd2, 9'd7, 3'd0);
      n = 0;
      while ((we_cnt - b_we) < 2 && n < 200) begin tick(); n++; end
      chk("t5_reach_byte2", 32'(we_cnt - b_we), 32'd2);
      repeat (4) tick();
      bus.Abort = 1'b1;
      tick();
      bus.Abort = 1'b0;
      chk("t5_busy", 32'(bus.Busy), 32'd0);
      chk("t5_sclk", 32'(bus.SPIClk), 32'd0);
      chk("t5_sdo", 32'(bus.SPIDo), 32'd1);
      repeat (200) tick();
      chk("t5_no_done", 32'(done_cnt - b_done), 32'd0);
      chk("t5_we_cnt", 32'(we_cnt - b_we), 32'd2);
      chk("t5_rx0", 32'(rx_mem[0]), 32'h10);
      chk("t5_rx1", 32'(rx_mem[1]), 32'h11);
      errs = 0;
      for (int i = 2; i < 8; i++) if (rx_mem[i] !== 8'h5A) errs++;
      chk("t5_untouched", 32'(errs), 32'd0);
      tx_mem[0] = 8'hA5;
      clear_rx();
      b_done = done_cnt;
      start_xfer(2'd2, 9'd0, 3'd0);
      wait_done(b_done, 100, "t5r_timeout");
      tick();
      chk("t5r_rx0", 32'(rx_mem[0]), 32'hA5);
      chk("t5r_addr", 32'(last_we_addr), 32'd0);

      // 6: Start while busy, Start with Abort, reset mid-transfer
      tx_mem[0] = 8'h66; tx_mem[1] = 8'h99;
      clear_rx();
      b_done = done_cnt; b_we = we_cnt; b_re = re_cnt;
      exp_hi = 2;
      start_xfer(2'd2, 9'd1, 3'd1);
      repeat (5) tick();
      bus.Mode = 2'd0; bus.Length = 9'h1FF; bus.ClkDiv = 3'd0;
      bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      wait_done(b_done, 300, "t6a_timeout");
      tick();
      chk("t6a_done_lat", 32'(done_cyc - start_cyc), 32'd69);
      chk("t6a_we_cnt", 32'(we_cnt - b_we), 32'd2);
      chk("t6a_re_cnt", 32'(re_cnt - b_re), 32'd2);
      chk("t6a_rx0", 32'(rx_mem[0]), 32'h66);
      chk("t6a_rx1", 32'(rx_mem[1]), 32'h99);
      repeat (40) tick();
      chk("t6a_idle", 32'(bus.Busy), 32'd0);

      b_done = done_cnt;
      bus.Start = 1'b1; bus.Abort = 1'b1;
      tick();
      bus.Start = 1'b0; bus.Abort = 1'b0;
      chk("t6b_busy", 32'(bus.Busy), 32'd0);
      chk("t6b_txre", 32'(bus.TxBufRe), 32'd0);
      repeat (50) tick();
      chk("t6b_no_done", 32'(done_cnt - b_done), 32'd0);

      b_done = done_cnt;
      exp_hi = 1;
      start_xfer(2'd2, 9'd3, 3'd0);
      repeat (25) tick();
      chk("t6c_midxfer", 32'(bus.TxBufAddr), 32'd1);
      Reset = 1'b1;
      tick();
      chk_reset_vals("t6c");
      Reset = 1'b0;
      repeat (50) tick();
      chk("t6c_no_done", 32'(done_cnt - b_done), 32'd0);
      chk("sdo_edges", 32'(do_bad), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
